// File: rtl/disp_pattern_seq.sv
// disp_pattern_seq
//   Pattern sequencer for segment/LED displays. A small writable pattern
//   store is stepped through at a programmable rate (one tick every
//   2**DIV_W clocks) in loop, ping-pong or one-shot order. It also supports
//   run/pause and manual single-step while paused.
//
//   Optional feature: define DISP_PATTERN_SEQ_BLANK_GAP_EN to insert one
//   blank tick period (GAP state) after every displayed entry.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (also clears the store)
//   wr_en    in   pattern write strobe
//   wr_addr  in   pattern write address; addresses >= PAT_LEN are ignored
//   wr_data  in   pattern data, 1 = segment lit
//   mode     in   0 loop, 1 ping-pong, 2 one-shot, 3 loop
//   run      in   1 = auto-advance on tick
//   step     in   single-cycle advance request, honoured only when run=0
//   seg_n    out  active-low segment drive (registered)
//   idx      out  current entry index
//   tick     out  one-cycle prescaler pulse
//   done     out  one-shot sequence complete
module disp_pattern_seq #(
    parameter int DIV_W   = 25,
    parameter int PAT_LEN = 8,
    parameter int SEG_W   = 14,
    parameter int IDX_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [SEG_W-1:0] wr_data,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             step,
    output logic [SEG_W-1:0] seg_n,
    output logic [IDX_W-1:0] idx,
    output logic             tick,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

`ifdef DISP_PATTERN_SEQ_BLANK_GAP_EN
    typedef enum logic [1:0] {ST_SHOW = 2'd0, ST_GAP = 2'd1, ST_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_SHOW = 2'd0, ST_DONE = 2'd2} state_t;
`endif

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               dir_down_reg, dir_down_next;
    logic [DIV_W-1:0]   div_reg;
    logic               tick_reg;
    logic               done_reg;
    logic [SEG_W-1:0]   seg_n_reg, seg_n_next;
    logic [SEG_W-1:0]   store_reg [PAT_LEN];
    logic [PAT_LEN-1:0] wr_hit;

    logic               adv;
    logic [IDX_W-1:0]   step_idx;
    logic               step_dir_down;
    logic               step_done;

    // ------------------------------------------------------------------
    // Prescaler: free-runs while run=1, parked at 0 while paused so the
    // first tick always comes a full period after run rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (run) begin
            div_reg  <= div_reg + DIV_W'(1);
            tick_reg <= (div_reg == {DIV_W{1'b1}});
        end else begin
            div_reg  <= '0;
            tick_reg <= 1'b0;
        end
    end

    assign adv = (run & tick_reg) | (~run & step);

    // ------------------------------------------------------------------
    // Pattern store. Each entry decodes its own write hit; an address past
    // the last entry matches nothing and is therefore dropped.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PAT_LEN; gi++) begin : g_wr_hit
            assign wr_hit[gi] = wr_en && (wr_addr == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAT_LEN; i++) begin
                store_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PAT_LEN; i++) begin
                if (wr_hit[i]) begin
                    store_reg[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode step: where the index goes on the next advance. Compares are
    // against LAST_IDX so a non-power-of-2 length never overruns.
    // ------------------------------------------------------------------
    always_comb begin
        step_idx      = idx_reg;
        step_dir_down = dir_down_reg;
        step_done     = 1'b0;
        case (mode)
            2'd1: begin
                if (PAT_LEN == 1) begin
                    step_idx = '0;
                end else if (!dir_down_reg) begin
                    if (idx_reg == LAST_IDX) begin
                        step_dir_down = 1'b1;
                        step_idx      = idx_reg - ONE_IDX;
                    end else begin
                        step_idx = idx_reg + ONE_IDX;
                    end
                end else begin
                    if (idx_reg == '0) begin
                        step_dir_down = 1'b0;
                        step_idx      = idx_reg + ONE_IDX;
                    end else begin
                        step_idx = idx_reg - ONE_IDX;
                    end
                end
            end
            2'd2: begin
                // Final entry stays on screen; the FSM moves to DONE.
                if (idx_reg == LAST_IDX) begin
                    step_done = 1'b1;
                end else begin
                    step_idx = idx_reg + ONE_IDX;
                end
            end
            default: begin
                step_idx = (idx_reg == LAST_IDX) ? '0 : idx_reg + ONE_IDX;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        dir_down_next = dir_down_reg;
        case (state_reg)
            ST_SHOW: begin
                if (adv) begin
                    if (step_done) begin
                        // One-shot end: no trailing blank even with gaps on.
                        state_next = ST_DONE;
                    end else begin
`ifdef DISP_PATTERN_SEQ_BLANK_GAP_EN
                        state_next = ST_GAP;
`else
                        idx_next      = step_idx;
                        dir_down_next = step_dir_down;
`endif
                    end
                end
            end
`ifdef DISP_PATTERN_SEQ_BLANK_GAP_EN
            ST_GAP: begin
                if (adv) begin
                    if (step_done) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_SHOW;
                        idx_next      = step_idx;
                        dir_down_next = step_dir_down;
                    end
                end
            end
`endif
            ST_DONE: begin
                // Advances are ignored; dropping run rearms from entry 0.
                if (!run) begin
                    state_next = ST_SHOW;
                    idx_next   = '0;
                end
            end
            default: begin
                state_next = ST_SHOW;
            end
        endcase
    end

    // Output register samples the current index, so seg_n trails idx by one.
    always_comb begin
        seg_n_next = ~store_reg[idx_reg];
`ifdef DISP_PATTERN_SEQ_BLANK_GAP_EN
        if (state_reg == ST_GAP) begin
            seg_n_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_SHOW;
            idx_reg      <= '0;
            dir_down_reg <= 1'b0;
            done_reg     <= 1'b0;
            seg_n_reg    <= '1;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            dir_down_reg <= dir_down_next;
            done_reg     <= (state_next == ST_DONE);
            seg_n_reg    <= seg_n_next;
        end
    end

    assign seg_n = seg_n_reg;
    assign idx   = idx_reg;
    assign tick  = tick_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_disp_pattern_seq.sv
module tb_disp_pattern_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [13:0] wr_data;
    logic [1:0]  mode;
    logic        run;
    logic        step;
    logic [13:0] seg_n;
    logic [1:0]  idx;
    logic        tick;
    logic        done;

    // Second instance with a non-power-of-2 length (3-bit address).
    logic        wr_en5;
    logic [2:0]  wr_addr5;
    logic [13:0] seg_n5;
    logic [2:0]  idx5;
    logic        tick5;
    logic        done5;

    int n_checks = 0;
    int n_pass   = 0;

    logic [13:0] pat [5];
    logic [13:0] pat_n [5];
    logic [1:0]  exp_idx [8];
    logic [2:0]  exp_idx5 [5];

    disp_pattern_seq #(.DIV_W(3), .PAT_LEN(4), .SEG_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mode(mode), .run(run), .step(step),
        .seg_n(seg_n), .idx(idx), .tick(tick), .done(done)
    );

    disp_pattern_seq #(.DIV_W(3), .PAT_LEN(5), .SEG_W(14)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_data(wr_data), .mode(mode), .run(run), .step(step),
        .seg_n(seg_n5), .idx(idx5), .tick(tick5), .done(done5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %04h exp %04h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got %04h exp %04h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        wr_en = 1'b0;
        wr_en5 = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic write4(input logic [1:0] a, input logic [13:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic write5(input logic [2:0] a, input logic [13:0] d);
        wr_addr5 = a;
        wr_data  = d;
        wr_en5   = 1'b1;
        cyc();
        wr_en5   = 1'b0;
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) begin
            write4(2'(i), pat[i]);
        end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 14'h0001; pat[1] = 14'h0002; pat[2] = 14'h0004;
        pat[3] = 14'h0008; pat[4] = 14'h0010;
        pat_n[0] = 14'h3FFE; pat_n[1] = 14'h3FFD; pat_n[2] = 14'h3FFB;
        pat_n[3] = 14'h3FF7; pat_n[4] = 14'h3FEF;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_en5 = 1'b0; wr_addr5 = '0;
        mode = 2'd0; run = 1'b0; step = 1'b0;
        cyc();
        cyc();
        check("rst_seg_n", 32'(seg_n), 32'h3FFF);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        cyc();

        // Loop mode: ticks every 8 cycles, seg_n one cycle behind idx.
        load4();
        check("loop_seg0", 32'(seg_n), 32'h3FFE);
        mode = 2'd0;
        run  = 1'b1;
        repeat (8) cyc();
        check("loop_tick1", 32'(tick), 32'h1);
        check("loop_idx_pre", 32'(idx), 32'h0);
        exp_idx[0] = 2'd1; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("loop_idx", 32'(idx), 32'(exp_idx[k]));
            check("loop_seg_lag", 32'(seg_n), 32'(pat_n[k]));
            cyc();
            check("loop_seg", 32'(seg_n), 32'(pat_n[(k + 1) % 4]));
            repeat (6) cyc();
        end

        // Ping-pong from reset.
        do_reset();
        mode = 2'd1;
        run  = 1'b1;
        repeat (8) cyc();
        exp_idx[0] = 2'd1; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd2;
        exp_idx[4] = 2'd1; exp_idx[5] = 2'd0; exp_idx[6] = 2'd1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check("pp_idx", 32'(idx), 32'(exp_idx[k]));
            repeat (7) cyc();
        end

        // One-shot: stops on the last entry with done set.
        do_reset();
        load4();
        mode = 2'd2;
        run  = 1'b1;
        repeat (8) cyc();
        for (int k = 1; k < 4; k++) begin
            cyc();
            check("os_idx", 32'(idx), 32'(k));
            repeat (7) cyc();
        end
        cyc();
        check("os_done", 32'(done), 32'h1);
        check("os_idx_last", 32'(idx), 32'h3);
        check("os_seg", 32'(seg_n), 32'h3FF7);
        repeat (40) cyc();
        check("os_done_hold", 32'(done), 32'h1);
        check("os_seg_hold", 32'(seg_n), 32'h3FF7);
        check("os_idx_hold", 32'(idx), 32'h3);
        run = 1'b0;
        cyc();
        check("os_rearm_idx", 32'(idx), 32'h0);
        check("os_rearm_done", 32'(done), 32'h0);

        // Manual step while paused (mode still one-shot).
        for (int k = 1; k < 4; k++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            check("step_idx", 32'(idx), 32'(k));
            check("step_tick", 32'(tick), 32'h0);
            cyc();
            cyc();
        end
        run = 1'b1;
        cyc();
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_run_idx", 32'(idx), 32'h3);
        check("step_run_done", 32'(done), 32'h0);
        run = 1'b0;
        cyc();

        // Write to the displayed entry while running, then async reset.
        do_reset();
        load4();
        mode = 2'd0;
        run  = 1'b1;
        repeat (8) cyc();
        cyc();
        check("wr_idx", 32'(idx), 32'h1);
        cyc();
        check("wr_seg_before", 32'(seg_n), 32'h3FFD);
        wr_addr = 2'd1;
        wr_data = 14'h2AAA;
        wr_en   = 1'b1;
        cyc();
        wr_en = 1'b0;
        check("wr_seg_edge", 32'(seg_n), 32'h3FFD);
        cyc();
        check("wr_seg_after", 32'(seg_n), 32'h1555);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_seg", 32'(seg_n), 32'h3FFF);
        check("async_idx", 32'(idx), 32'h0);
        run = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        check("store_cleared", 32'(seg_n), 32'h3FFF);

        // Length-5 instance: out-of-range writes dropped, wrap 4 -> 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write5(3'(i), pat[i]);
        end
        for (int i = 5; i < 8; i++) begin
            write5(3'(i), 14'h0000);
        end
        cyc();
        check("len5_seg0", 32'(seg_n5), 32'h3FFE);
        mode = 2'd0;
        run  = 1'b1;
        repeat (8) cyc();
        exp_idx5[0] = 3'd1; exp_idx5[1] = 3'd2; exp_idx5[2] = 3'd3;
        exp_idx5[3] = 3'd4; exp_idx5[4] = 3'd0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("len5_idx", 32'(idx5), 32'(exp_idx5[k]));
            cyc();
            check("len5_seg", 32'(seg_n5), 32'(pat_n[(k + 1) % 5]));
            repeat (6) cyc();
        end
        run = 1'b0;

`ifdef DISP_PATTERN_SEQ_BLANK_GAP_EN
        // Blank gap after every entry: 8 ticks (64 cycles) per loop.
        do_reset();
        load4();
        mode = 2'd0;
        run  = 1'b1;
        repeat (8) cyc();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("gap_idx", 32'(idx), 32'((k / 2) % 4));
            cyc();
            if (k % 2 == 1) begin
                check("gap_blank", 32'(seg_n), 32'h3FFF);
            end else begin
                check("gap_seg", 32'(seg_n), 32'(pat_n[(k / 2) % 4]));
            end
            repeat (6) cyc();
        end
        run = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_pattern_seq.md
Name: disp_pattern_seq

Overview:
- Parametrised pattern sequencer for segment/LED displays on the Versa boards.
- Generalises the fixed-rate looping demo into a writable pattern store with a programmable rate and loop, ping-pong and one-shot modes.
- Supports run/pause and manual single-step.
- Sits between a board top level (pattern loader or host) and the active-low segment pins.

Parameters:
- DIV_W, 25, prescaler width; one advance tick every 2**DIV_W clk cycles.
- PAT_LEN, 8, number of pattern entries (>=1).
- SEG_W, 14, segments per entry.
- IDX_W, $clog2(PAT_LEN) (min 1), width of index/address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  pattern write strobe
- wr_addr  in  IDX_W  pattern write address
- wr_data  in  SEG_W  pattern data, 1 = segment lit
- mode  in  2  0 loop, 1 ping-pong, 2 one-shot, 3 treated as loop
- run  in  1  1 = auto-advance on tick
- step  in  1  single-cycle advance request, honoured only when run=0
- seg_n  out  SEG_W  active-low segment drive (registered)
- idx  out  IDX_W  current entry index
- tick  out  1  one-cycle prescaler pulse
- done  out  1  one-shot complete

Behaviour:
- Reset values:
  - All outputs: seg_n all ones, idx 0, tick 0, done 0.
  - Internal: prescaler 0, direction up, state SHOW.
  - Pattern store cleared to 0.
- Prescaler:
  - DIV_W-bit counter increments while run=1 and is held at 0 while run=0.
  - tick=1 for the single cycle after the counter wraps (all ones -> 0), so the first tick comes 2**DIV_W cycles after run rises.
- Advance event adv = (run & tick) | (~run & step). step while run=1 is ignored.
- Pattern store:
  - PAT_LEN x SEG_W registers; write on wr_en at the clock edge.
  - wr_addr >= PAT_LEN is ignored.
  - Writes are accepted in every state.
- States:
  - SHOW: displays entry idx. On adv, next idx follows the mode (below); with BLANK_GAP_EN, go to GAP instead of moving idx.
  - GAP (feature only): seg_n all ones. On adv, apply the mode step and return to SHOW.
  - DONE: seg_n holds the last entry and done=1. adv is ignored. When run=0, go to SHOW with idx 0 and done 0 on the next edge.
- Mode step:
  - Loop: idx+1, wrapping PAT_LEN-1 -> 0.
  - Ping-pong:
    - Direction up: idx+1; at PAT_LEN-1, flip to down and go to idx-1.
    - Direction down: mirror image, flipping at 0.
    - Endpoints are shown once per sweep. PAT_LEN=1 stays at 0.
  - One-shot: idx+1. At PAT_LEN-1, go to DONE (idx unchanged).
  - Mode changes take effect at the next adv. The direction flag persists across mode changes and resets to up only on rst_n.
- Output timing:
  - seg_n = ~store[idx] is registered each cycle (all ones in GAP).
  - seg_n lags an idx change by exactly 1 cycle.
  - A write to the displayed address appears on seg_n 1 cycle after the write edge.
- Width rules: idx arithmetic is done in IDX_W bits with explicit compares against PAT_LEN-1. A non-power-of-2 PAT_LEN never produces idx >= PAT_LEN.
- Reset mid-operation: rst_n low asynchronously forces all reset values, including clearing the store.

Optional Feature:
- Macro: DISP_PATTERN_SEQ_BLANK_GAP_EN
- Defined:
  - Each entry is followed by one blank tick period (GAP state, seg_n all ones, idx unchanged).
  - A full loop takes 2*PAT_LEN ticks.
  - In one-shot mode, the final entry goes directly to DONE with no trailing gap.
- Undefined:
  - The GAP state is not built; entries advance every adv.
  - A full loop takes PAT_LEN ticks.

Test Plan (DIV_W=3, PAT_LEN=4, SEG_W=14, macro undefined unless stated):
- Write 0x0001, 0x0002, 0x0004, 0x0008 to addresses 0-3; run=1, mode=0 -> tick every 8 cycles; idx sequence 0,1,2,3,0. seg_n = 0x3FFE, 0x3FFD, 0x3FFB, 0x3FF7, 0x3FFE, each appearing 1 cycle after the idx change.
- mode=1, run=1 from reset -> idx 0,1,2,3,2,1,0,1 on successive ticks.
- mode=2 -> idx 0,1,2,3 then done=1 and seg_n held at 0x3FF7 for 40 more cycles. Drop run -> next edge idx=0, done=0.
- run=0, pulse step 3 times (one cycle each, spaced) -> idx 1,2,3; tick stays 0. step pulsed with run=1 between ticks -> no change.
- Write 0x2AAA to the displayed address while running -> seg_n=0x1555 one cycle later. Write to address 5 -> no effect. Assert rst_n low mid-sequence -> seg_n=0x3FFF and idx=0 immediately (asynchronous).
- Macro defined, mode=0 -> per tick: entry0, blank (0x3FFF), entry1, blank...; idx is constant across each entry/blank pair; loop period is 64 cycles.
